// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: four extension modes, tag sideband, valid/ready
// handshake with a main output register backed by one skid register, and flush.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [TAG_W-1:0] tag_o
);

    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] d,
                                                    input logic [1:0]      m);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] res;
        sext = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
        case (m)
            2'd0:    res = sext;
            2'd1:    res = {{(OUT_W-IN_W){1'b0}}, d};
            2'd2:    res = {d, {(OUT_W-IN_W){1'b0}}};
            2'd3:    res = sext << SHAMT;
            default: res = sext;
        endcase
        return res;
    endfunction

    logic             main_valid_r;
    logic [OUT_W-1:0] main_data_r;
    logic [TAG_W-1:0] main_tag_r;
    logic             skid_valid_r;
    logic [OUT_W-1:0] skid_data_r;
    logic [TAG_W-1:0] skid_tag_r;

    logic             accept_s;
    logic             consume_s;
    logic [OUT_W-1:0] ext_s;

    // Handshake qualifiers and the combinational extension of the offered input
    always_comb begin
        accept_s  = valid_i & ~skid_valid_r;
        consume_s = main_valid_r & out_ready_i;
        ext_s     = extend_imm(data_i, mode_i);
    end

    // Main/skid storage; the skid always drains into main before any newer input
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid_r <= 1'b0;
            main_data_r  <= {OUT_W{1'b0}};
            main_tag_r   <= {TAG_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {OUT_W{1'b0}};
            skid_tag_r   <= {TAG_W{1'b0}};
        end else if (flush_i) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!main_valid_r || consume_s) begin
            if (skid_valid_r) begin
                main_valid_r <= 1'b1;
                main_data_r  <= skid_data_r;
                main_tag_r   <= skid_tag_r;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_valid_r <= 1'b1;
                main_data_r  <= ext_s;
                main_tag_r   <= tag_i;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= ext_s;
            skid_tag_r   <= tag_i;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    // Outputs come straight from registers; in_ready never sees out_ready_i
    always_comb begin
        in_ready_o  = ~skid_valid_r;
        out_valid_o = main_valid_r;
        data_o      = main_data_r;
        tag_o       = main_tag_r;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe with a queue scoreboard of expected results.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] data;
    logic [1:0]  mode;
    logic [4:0]  tag, tag_out;
    logic [31:0] data_out;

    logic        valid12, in_ready12, out_valid12;
    logic [11:0] data12;
    logic [1:0]  mode12;
    logic [4:0]  tag12, tag_out12;
    logic [31:0] data_out12;

    int vectors    = 0;
    int miscompares = 0;
    logic [36:0] sb_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2), .TAG_W(5)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .in_ready_o(in_ready),
        .data_i(data), .mode_i(mode), .tag_i(tag), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_o(data_out), .tag_o(tag_out)
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .SHAMT(1), .TAG_W(5)) u_dut12 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid12), .in_ready_o(in_ready12),
        .data_i(data12), .mode_i(mode12), .tag_i(tag12), .flush_i(1'b0),
        .out_valid_o(out_valid12), .out_ready_i(1'b1),
        .data_o(data_out12), .tag_o(tag_out12)
    );

    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        logic signed [31:0] s;
        s = $signed(d);
        case (m)
            2'd0:    return s;
            2'd1:    return {16'h0000, d};
            2'd2:    return {d, 16'h0000};
            default: return s <<< 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: score the handshakes implied by the current inputs, then advance
    task automatic tick();
        logic [36:0] e;
        #1;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {63'd0, sb_q.size() != 0}, 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("sb_data", {32'd0, data_out}, {32'd0, e[36:5]});
                    chk("sb_tag", {59'd0, tag_out}, {59'd0, e[4:0]});
                end
            end
            if (valid && in_ready) sb_q.push_back({model(data, mode), tag});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                         input logic [4:0] t);
        valid = v; data = d; mode = m; tag = t;
    endtask

    initial begin
        logic [31:0] exp_mode [4];
        exp_mode[0] = 32'hFFFF8001; exp_mode[1] = 32'h00008001;
        exp_mode[2] = 32'h80010000; exp_mode[3] = 32'hFFFE0004;

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        valid12 = 1'b0; data12 = 12'h000; mode12 = 2'd0; tag12 = 5'd0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_data", {32'd0, data_out}, 64'd0);
        chk("rst_tag", {59'd0, tag_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode coverage, one result per cycle with one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h8001, 2'(i), 5'(i + 1));
            tick();
            chk("mode_valid", {63'd0, out_valid}, 64'd1);
            chk("mode_data", {32'd0, data_out}, {32'd0, exp_mode[i]});
            chk("mode_tag", {59'd0, tag_out}, 64'(i + 1));
        end
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        tick();
        chk("mode_drained", {63'd0, out_valid}, 64'd0);

        // Backpressure: two accepted, third held off until the skid drains
        out_ready = 1'b0;
        drive(1'b1, 16'h0007, 2'd0, 5'd7); tick();
        chk("bp_ready_after1", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 16'hF008, 2'd3, 5'd8); tick();
        chk("bp_ready_after2", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 16'h0009, 2'd1, 5'd9); tick();
        chk("bp_ready_hold", {63'd0, in_ready}, 64'd0);
        chk("bp_hold_tag", {59'd0, tag_out}, 64'd7);
        chk("bp_hold_data", {32'd0, data_out}, 64'h7);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        for (int i = 0; i < 2; i++) tick();
        chk("bp_queue_empty", 64'(sb_q.size()), 64'd0);
        chk("bp_idle", {63'd0, out_valid}, 64'd0);

        // Streaming at full throughput
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(i * 16'h0911), 2'(i % 4), 5'(i));
            tick();
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        tick();
        chk("stream_queue_empty", 64'(sb_q.size()), 64'd0);

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 2'd0, 5'd20); tick();
        drive(1'b1, 16'h2222, 2'd1, 5'd21); tick();
        chk("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 16'h3333, 2'd2, 5'd30); tick();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("fl_nothing_out", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        drive(1'b1, 16'h4444, 2'd0, 5'd11); tick();
        drive(1'b1, 16'h5555, 2'd0, 5'd12); tick();
        drive(1'b0, 16'h0000, 2'd0, 5'd0);
        chk("ar_pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
        chk("ar_data", {32'd0, data_out}, 64'd0);
        chk("ar_tag", {59'd0, tag_out}, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Narrow-input variant: IN_W=12, SHAMT=1
        valid12 = 1'b1; data12 = 12'h800; mode12 = 2'd3; tag12 = 5'd3;
        @(posedge clk); #1;
        chk("p12_mode3", {32'd0, data_out12}, 64'hFFFFF000);
        chk("p12_tag", {59'd0, tag_out12}, 64'd3);
        @(negedge clk);
        mode12 = 2'd2;
        @(posedge clk); #1;
        chk("p12_mode2", {32'd0, data_out12}, 64'h80000000);
        chk("p12_valid", {63'd0, out_valid12}, 64'd1);
        @(negedge clk);
        valid12 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the pipelined CPU decode/execute path.
- Extends an IN_W-bit immediate to OUT_W bits using one of four per-transaction modes: sign, zero, upper, or sign-shifted for branch offsets.
- Each result is registered with a sideband tag.
- A valid/ready handshake with a 2-entry skid buffer lets upstream keep issuing while downstream stalls.
- A flush clears in-flight entries on branch mispredict.

Parameters:
- IN_W, 16, immediate input width; legal range 1 to OUT_W-1.
- OUT_W, 32, extended output width.
- SHAMT, 2, left-shift amount for mode 3; legal range 0 to OUT_W-1.
- TAG_W, 5, sideband tag width (e.g. destination register index); carried unchanged.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- valid_i  input  1  upstream offers a transaction.
- in_ready_o  output  1  block can accept a transaction this cycle.
- data_i  input  IN_W  raw immediate field.
- mode_i  input  2  0=sign, 1=zero, 2=upper, 3=sign then shift left SHAMT.
- tag_i  input  TAG_W  sideband tag, travels with data.
- flush_i  input  1  discard all held and incoming transactions.
- out_valid_o  output  1  data_o/tag_o hold a valid result.
- out_ready_i  input  1  downstream consumes the result this cycle.
- data_o  output  OUT_W  extended immediate.
- tag_o  output  TAG_W  tag of the current output.

Behaviour:
- Reset: while rst_i=0, asynchronously clear state and outputs.
  - out_valid_o=0, data_o=0, tag_o=0, skid entry invalid and zeroed.
  - in_ready_o=1.
- Extension is combinational on the input side; the result is captured into storage, so minimum latency is 1 cycle from acceptance to out_valid_o.
- Mode 0: bits [IN_W-1:0]=data_i; upper OUT_W-IN_W bits replicate data_i[IN_W-1].
- Mode 1: upper bits are 0.
- Mode 2: data_i placed at bits [OUT_W-1:OUT_W-IN_W]; lower bits are 0.
- Mode 3: mode-0 result shifted left by SHAMT; bits shifted past OUT_W-1 are dropped; vacated low bits are 0.
- Storage is a main register (drives outputs) plus one skid register.
- in_ready_o = NOT skid_valid, taken from the registered state. No combinational path from out_ready_i to in_ready_o.
- Accept: valid_i=1 and in_ready_o=1 at the edge.
- Consume: out_valid_o=1 and out_ready_i=1 at the edge.
- Per edge, when flush_i=0:
  - Main empty (or consumed) and skid empty: an accepted input loads main.
  - Main consumed and skid full: skid moves to main. in_ready_o is 0 that cycle, so there is no input.
  - Main full, not consumed, input accepted: input loads skid. in_ready_o drops next cycle.
  - Main full, not consumed, no accept: hold all state.
  - Accept and consume in the same edge with skid empty: new input replaces main; out_valid_o stays 1.
- Order: outputs appear in acceptance order. The skid entry always reaches the outputs before any later accepted input.
- Data stability: data_o and tag_o are stable while out_valid_o=1 and out_ready_i=0.
- flush_i=1 at an edge:
  - Both entries become invalid and any accepted input is discarded.
  - Next cycle: out_valid_o=0, in_ready_o=1.
  - data_o/tag_o retain their last values; they are don't-care when out_valid_o=0.
  - Flush takes priority over accept and consume.
- Reset asserted mid-operation drops all entries immediately; no partial transaction survives.
- Inputs are ignored when valid_i=0. mode_i and tag_i are sampled only on accept.

Test Plan:
- Mode coverage (defaults): out_ready_i=1; accept data_i=16'h8001 in modes 0, 1, 2, 3 on consecutive cycles -> data_o = 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, each one cycle after its accept, with tags 1, 2, 3, 4 in order.
- Backpressure: hold out_ready_i=0 and offer 3 back-to-back inputs (tags 7, 8, 9).
  - First two accepted; in_ready_o=0 from the cycle after the second accept; data_o holds tag 7's result.
  - Release out_ready_i -> tags 7, 8, 9 delivered in order with no loss or duplication.
- Streaming: valid_i=1 and out_ready_i=1 for 20 cycles with incrementing data -> out_valid_o=1 every cycle after the first, throughput 1/cycle, in_ready_o never drops.
- Flush with both entries full and valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1; the flushed-cycle input never appears at the outputs.
- Async reset: assert rst_i=0 between clock edges with both entries full -> out_valid_o=0, data_o=0, tag_o=0 immediately, in_ready_o=1.
- Parameter variant IN_W=12, OUT_W=32, SHAMT=1: mode 3 with data_i=12'h800 -> data_o=32'hFFFFF000; mode 2 -> 32'h80000000.
